pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_perf_cnt.sv | 23 ++
 rtl/pipe_stage_elastic.sv | 112 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: handshake state encoding and the legacy IF/ID payload width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    localparam int IFID_W = 96;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with increment enable; clears only on reset.
module pipe_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, two-entry skid buffer, stall/flush.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                 DATA_W           = IFID_W,
    parameter logic [DATA_W-1:0]  FLUSH_VAL        = '0,
    parameter bit                 FLUSH_OVER_STALL = 1'b0,
    parameter int                 CNT_W            = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;
    logic              flush_eff;

    // Outputs come straight from registers, so o_ready has no path from i_ready/i_stall.
    assign o_ready = (state_q != ST_SKID);
    assign o_valid = (state_q != ST_EMPTY);
    assign o_data  = main_q;

    assign in_fire   = i_valid & o_ready;
    assign out_fire  = o_valid & i_ready & ~i_stall;
    assign flush_eff = i_flush & (FLUSH_OVER_STALL | ~i_stall);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_eff) begin
            state_d = ST_EMPTY;
            main_d  = FLUSH_VAL;
            skid_d  = FLUSH_VAL;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = i_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = i_data;
                    end else if (in_fire) begin
                        state_d = ST_SKID;
                        skid_d  = i_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    assign stall_inc = o_valid & ~(i_ready & ~i_stall);

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (stall_inc),
        .count (o_stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (flush_eff),
        .count (o_flush_cnt)
    );
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: directed vectors, decoupled output monitor.
module tb_pipe_stage_elastic;

    localparam int          DW    = 16;
    localparam int          CW    = 4;
    localparam logic [15:0] FV    = 16'hDEAD;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [3:0] EXP_ST10 = 4'd10;
    localparam logic [3:0] EXP_ST20 = 4'd15;
    localparam logic [3:0] EXP_FL3  = 4'd3;
`else
    localparam logic [3:0] EXP_ST10 = 4'd0;
    localparam logic [3:0] EXP_ST20 = 4'd0;
    localparam logic [3:0] EXP_FL3  = 4'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_ready, i_stall, i_flush;
    logic [DW-1:0] i_data;
    logic          rdy0, vld0, rdy1, vld1;
    logic [DW-1:0] dat0, dat1;
    logic [CW-1:0] scnt0, fcnt0, scnt1, fcnt1;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .FLUSH_VAL(FV), .FLUSH_OVER_STALL(1'b0), .CNT_W(CW)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy0), .i_data(i_data),
        .o_valid(vld0), .i_ready(i_ready), .o_data(dat0), .i_stall(i_stall),
        .i_flush(i_flush), .o_stall_cnt(scnt0), .o_flush_cnt(fcnt0)
    );

    pipe_stage_elastic #(.DATA_W(DW), .FLUSH_VAL(FV), .FLUSH_OVER_STALL(1'b1), .CNT_W(CW)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy1), .i_data(i_data),
        .o_valid(vld1), .i_ready(i_ready), .o_data(dat1), .i_stall(i_stall),
        .i_flush(i_flush), .o_stall_cnt(scnt1), .o_flush_cnt(fcnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every released payload of dut0 must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && vld0 && i_ready && !i_stall && !i_flush) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected none at %0t", dat0, $time);
                end else begin
                    chk("sb_data", 32'(dat0), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_data = '0;
        repeat (2) tick();
        chk("rst_valid", 32'(vld0), 32'd0);
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_data",  32'(dat0), 32'(FV));
        chk("rst_scnt",  32'(scnt0), 32'd0);
        rst = 1'b0;
        tick();

        // Streaming 0x1..0x8
        i_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1'b1;
            i_data  = DW'(k);
            sb_q.push_back(DW'(k));
            tick();
            chk("stream_ready", 32'(rdy0), 32'd1);
        end
        i_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(sb_q.size()), 32'd0);
        chk("stream_empty", 32'(vld0), 32'd0);

        // Backpressure A, B, C
        i_valid = 1'b1; i_data = 16'h000A; sb_q.push_back(16'h000A);
        tick();
        i_ready = 1'b0; i_data = 16'h000B; sb_q.push_back(16'h000B);
        tick();
        chk("bp_ready_low", 32'(rdy0), 32'd0);
        chk("bp_hold_a", 32'(dat0), 32'h000A);
        i_data = 16'h000C; sb_q.push_back(16'h000C);
        tick();
        chk("bp_still_low", 32'(rdy0), 32'd0);
        chk("bp_still_a", 32'(dat0), 32'h000A);
        chk("bp_valid", 32'(vld0), 32'd1);
        i_ready = 1'b1;
        tick();
        chk("bp_recover_ready", 32'(rdy0), 32'd1);
        chk("bp_b", 32'(dat0), 32'h000B);
        tick();
        i_valid = 1'b0;
        chk("bp_c", 32'(dat0), 32'h000C);
        tick();
        chk("bp_drained", 32'(sb_q.size()), 32'd0);
        chk("bp_empty", 32'(vld0), 32'd0);

        // Flush while in SKID
        i_ready = 1'b0;
        i_valid = 1'b1; i_data = 16'h0011;
        tick();
        i_data = 16'h0022;
        tick();
        chk("fl_skid", 32'(rdy0), 32'd0);
        i_flush = 1'b1; i_data = 16'h0033;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        chk("fl_valid", 32'(vld0), 32'd0);
        chk("fl_ready", 32'(rdy0), 32'd1);
        chk("fl_data", 32'(dat0), 32'(FV));
        i_ready = 1'b1;
        repeat (2) tick();
        chk("fl_nothing_left", 32'(vld0), 32'd0);

        // Stall/flush priority with main=0x55
        i_ready = 1'b0;
        i_valid = 1'b1; i_data = 16'h0055;
        tick();
        i_valid = 1'b0; i_stall = 1'b1; i_flush = 1'b1;
        tick();
        i_stall = 1'b0; i_flush = 1'b0;
        chk("prio0_valid", 32'(vld0), 32'd1);
        chk("prio0_data", 32'(dat0), 32'h0055);
        chk("prio1_valid", 32'(vld1), 32'd0);
        chk("prio1_data", 32'(dat1), 32'(FV));
        sb_q.push_back(16'h0055);
        i_ready = 1'b1;
        tick();
        chk("prio0_released", 32'(vld0), 32'd0);

        // Asynchronous reset while in SKID
        i_ready = 1'b0;
        i_valid = 1'b1; i_data = 16'h0044;
        tick();
        i_data = 16'h0045;
        tick();
        i_valid = 1'b0;
        chk("ar_skid", 32'(rdy0), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(vld0), 32'd0);
        chk("ar_ready", 32'(rdy0), 32'd1);
        chk("ar_data", 32'(dat0), 32'(FV));
        chk("ar_valid1", 32'(vld1), 32'd0);
        tick();
        rst = 1'b0;
        chk("ar_scnt_clr", 32'(scnt0), 32'd0);
        chk("ar_fcnt_clr", 32'(fcnt0), 32'd0);

        // Counters: 20 stalled cycles then 3 flushes
        i_valid = 1'b1; i_data = 16'h0077;
        tick();
        i_valid = 1'b0;
        repeat (10) tick();
        chk("cnt_stall10", 32'(scnt0), 32'(EXP_ST10));
        repeat (10) tick();
        chk("cnt_stall_sat", 32'(scnt0), 32'(EXP_ST20));
        chk("cnt_stall_sat1", 32'(scnt1), 32'(EXP_ST20));
        i_flush = 1'b1;
        repeat (3) tick();
        i_flush = 1'b0;
        chk("cnt_flush", 32'(fcnt0), 32'(EXP_FL3));
        chk("cnt_flush1", 32'(fcnt1), 32'(EXP_FL3));
        chk("cnt_stall_held", 32'(scnt0), 32'(EXP_ST20));

        tick();
        chk("final_queue", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
